// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main control unit for the multicycle RV32I datapath. A Moore state machine
// steps each instruction through fetch, decode, execute, memory and writeback.
// It drives every datapath enable and mux select.
//
// Parameters:
//   ENABLE_UTYPE  : 1 = lui (0110111) is decoded, 0 = lui is flagged illegal
//   MEM_HANDSHAKE : 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready,
//                   0 = mem_ready is ignored (treated as always 1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   op[6:0]    in   opcode field of the instruction register
//   mem_ready  in   memory accepted/completed the current access
//   PCUpdate, IRWrite, RegWrite, MemWrite, Branch   out  datapath strobes
//   AdrSrc     out  memory address select (0 = PC, 1 = ALU result)
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp              out  2-bit selects / ALU class
//   ImmSrc[2:0] out immediate format, decoded from op in every state
//   illegal_op out  one-cycle pulse in DECODE on an unimplemented opcode
//   state_o[3:0] out current state, for debug and coverage
//
// Memory handshake (valid/ready): the controller presents an access for as
// long as it sits in FETCH, MEMREAD or MEMWRITE; the access completes in the
// cycle where mem_ready is 1, and only then does the state advance.
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter bit ENABLE_UTYPE  = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_e state_q;
    state_e state_d;
    logic   ready;

    // Without the handshake the memory is assumed to always complete in one cycle.
    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCUpdate   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 computed by the ALU while the instruction is read.
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCUpdate  = ready;
                if (ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target (oldPC + imm).
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI: begin
                        if (ENABLE_UTYPE) begin
                            state_d = S_LUI;
                        end else begin
                            state_d    = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    end
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                // Write stays asserted for the whole access, including waits.
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // Return address (oldPC + 4) is formed here; target came from DECODE.
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_LUI: begin
                // 0 + U-immediate.
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset aborts whatever is in flight: no architectural side effects.
        if (!reset_n) begin
            PCUpdate   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            Branch     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE: ImmSrc = 3'b000;
            OP_STORE:          ImmSrc = 3'b001;
            OP_BEQ:            ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI:            ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [6:0] op;
  logic       mem_ready;

  // a_*: default parameters; b_*: ENABLE_UTYPE=0, MEM_HANDSHAKE=0
  logic a_pcu, a_irw, a_rw, a_mw, a_br, a_adr, a_ill;
  logic [1:0] a_rs, a_sa, a_sb, a_aop;
  logic [2:0] a_imm;
  logic [3:0] a_st;
  logic b_pcu, b_irw, b_rw, b_mw, b_br, b_adr, b_ill;
  logic [1:0] b_rs, b_sa, b_sb, b_aop;
  logic [2:0] b_imm;
  logic [3:0] b_st;

  multicycle_ctrl_fsm dut_a (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .PCUpdate(a_pcu), .IRWrite(a_irw), .RegWrite(a_rw), .MemWrite(a_mw),
    .Branch(a_br), .AdrSrc(a_adr), .ResultSrc(a_rs), .ALUSrcA(a_sa),
    .ALUSrcB(a_sb), .ALUOp(a_aop), .ImmSrc(a_imm), .illegal_op(a_ill),
    .state_o(a_st)
  );

  multicycle_ctrl_fsm #(.ENABLE_UTYPE(1'b0), .MEM_HANDSHAKE(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .PCUpdate(b_pcu), .IRWrite(b_irw), .RegWrite(b_rw), .MemWrite(b_mw),
    .Branch(b_br), .AdrSrc(b_adr), .ResultSrc(b_rs), .ALUSrcA(b_sa),
    .ALUSrcB(b_sb), .ALUOp(b_aop), .ImmSrc(b_imm), .illegal_op(b_ill),
    .state_o(b_st)
  );

  wire [13:0] a_vec = {a_pcu, a_irw, a_rw, a_mw, a_br, a_adr, a_rs, a_sa, a_sb, a_aop};
  wire [13:0] b_vec = {b_pcu, b_irw, b_rw, b_mw, b_br, b_adr, b_rs, b_sa, b_sb, b_aop};

  // ---------------- reference model ----------------
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
  localparam int ER = 6, EI = 7, AWB = 8, BQ = 9, JL = 10, LU = 11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  int checks = 0;
  int errors = 0;
  int mw_cycles;
  int rw_cycles;

  // Output vector {PCUpdate,IRWrite,RegWrite,MemWrite,Branch,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  function automatic logic [13:0] exp_out(input int s, input logic rdy);
    logic pcu, irw, rw, mw, br, adr;
    logic [1:0] rs, sa, sb, aop;
    {pcu, irw, rw, mw, br, adr} = 6'b0;
    {rs, sa, sb, aop} = 8'b0;
    case (s)
      F:   begin sb = 2'b10; rs = 2'b10; irw = rdy; pcu = rdy; end
      D:   begin sa = 2'b01; sb = 2'b01; end
      MA:  begin sa = 2'b10; sb = 2'b01; end
      MR:  begin adr = 1'b1; end
      MWB: begin rs = 2'b01; rw = 1'b1; end
      MW:  begin adr = 1'b1; mw = 1'b1; end
      ER:  begin sa = 2'b10; aop = 2'b10; end
      EI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      AWB: begin rw = 1'b1; end
      BQ:  begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
      JL:  begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
      LU:  begin sa = 2'b11; sb = 2'b01; end
      default: ;
    endcase
    return {pcu, irw, rw, mw, br, adr, rs, sa, sb, aop};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      OP_LW, OP_I: return 3'b000;
      OP_SW:       return 3'b001;
      OP_BEQ:      return 3'b010;
      OP_JAL:      return 3'b011;
      OP_LUI:      return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Run one instruction on DUT a (sel=0) or b (sel=1).
  // wf / wm: mem_ready=0 cycles in FETCH / in the memory state (-1 = random).
  task automatic run_instr(input logic [6:0] o, input int wf, input int wm, input bit sel);
    int path[$];
    int st_q[$];
    bit mr_q[$];
    bit hs;
    bit illegal;
    int w;
    int s;
    bit mr;
    logic [3:0] ost;
    logic [13:0] ovec, evec;
    logic oill;
    logic [2:0] oimm;
    hs = !sel;
    case (o)
      OP_LW:   path = {F, D, MA, MR, MWB};
      OP_SW:   path = {F, D, MA, MW};
      OP_R:    path = {F, D, ER, AWB};
      OP_I:    path = {F, D, EI, AWB};
      OP_BEQ:  path = {F, D, BQ};
      OP_JAL:  path = {F, D, JL, AWB};
      OP_LUI:  if (!sel) path = {F, D, LU, AWB}; else path = {F, D};
      default: path = {F, D};
    endcase
    illegal = (path.size() == 2);
    foreach (path[i]) begin
      if (path[i] == F || path[i] == MR || path[i] == MW) begin
        if (hs) begin
          w = (path[i] == F) ? wf : wm;
          if (w < 0) w = $urandom_range(0, 3);
          repeat (w) begin st_q.push_back(path[i]); mr_q.push_back(1'b0); end
          st_q.push_back(path[i]); mr_q.push_back(1'b1);
        end else begin
          st_q.push_back(path[i]); mr_q.push_back(1'($urandom_range(0, 1)));
        end
      end else begin
        st_q.push_back(path[i]); mr_q.push_back(1'($urandom_range(0, 1)));
      end
    end
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      mr = mr_q.pop_front();
      op = o;
      mem_ready = mr;
      #2;
      ost  = sel ? b_st : a_st;
      ovec = sel ? b_vec : a_vec;
      oill = sel ? b_ill : a_ill;
      oimm = sel ? b_imm : a_imm;
      evec = exp_out(s, hs ? mr : 1'b1);
      if (ovec[10]) mw_cycles++;
      if (ovec[11]) rw_cycles++;
      checks++;
      if (ost !== 4'(s)) begin
        errors++;
        $display("FAIL state op=%b sel=%0d: got %0d expected %0d", o, sel, ost, s);
      end
      checks++;
      if (ovec !== evec) begin
        errors++;
        $display("FAIL outputs op=%b sel=%0d state=%0d: got %b expected %b", o, sel, s, ovec, evec);
      end
      checks++;
      if (oill !== (illegal && s == D)) begin
        errors++;
        $display("FAIL illegal_op op=%b sel=%0d state=%0d: got %b expected %b", o, sel, s, oill, (illegal && s == D));
      end
      checks++;
      if (oimm !== exp_imm(o)) begin
        errors++;
        $display("FAIL ImmSrc op=%b sel=%0d: got %b expected %b", o, sel, oimm, exp_imm(o));
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [8];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI, OP_SYS};
    if ($urandom_range(0, 4) == 0) return 7'($urandom_range(0, 127));
    return ops[$urandom_range(0, 7)];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int sts [5];
    bit mrs [5];
    sts = '{F, D, MA, MW, MW};
    mrs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op = OP_SW;
      mem_ready = mrs[i];
      #2;
      checks++;
      if (a_st !== 4'(sts[i]) || a_mw !== (sts[i] == MW)) begin
        errors++;
        $display("FAIL reset_prep cycle %0d: got state=%0d MemWrite=%b expected state=%0d", i, a_st, a_mw, sts[i]);
      end
      @(negedge clk);
    end
    // assert reset while store is waiting on memory
    reset_n = 1'b0;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if ({a_pcu, a_irw, a_rw, a_mw, a_br, a_ill, b_pcu, b_irw, b_rw, b_mw, b_br, b_ill} !== 12'b0) begin
        errors++;
        $display("FAIL reset_strobes cycle %0d: got a=%b%b%b%b%b%b b=%b%b%b%b%b%b expected all 0",
                 k, a_pcu, a_irw, a_rw, a_mw, a_br, a_ill, b_pcu, b_irw, b_rw, b_mw, b_br, b_ill);
      end
      if (k > 0) begin
        checks++;
        if (a_st !== 4'd0) begin
          errors++;
          $display("FAIL reset_state cycle %0d: got %0d expected 0", k, a_st);
        end
      end
      @(negedge clk);
    end
    reset_n = 1'b1;
    mem_ready = 1'b1;
    #2;
    checks++;
    if (a_st !== 4'd0 || a_irw !== 1'b1 || a_pcu !== 1'b1 || a_mw !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got state=%0d IRWrite=%b PCUpdate=%b MemWrite=%b expected 0 1 1 0",
               a_st, a_irw, a_pcu, a_mw);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_lw();
    rw_cycles = 0;
    run_instr(OP_LW, 0, 0, 1'b0);
    checks++;
    if (rw_cycles !== 1) begin
      errors++;
      $display("FAIL lw_regwrite_count: got %0d expected 1", rw_cycles);
    end
  endtask

  task automatic test_sw_wait();
    mw_cycles = 0;
    rw_cycles = 0;
    run_instr(OP_SW, 0, 2, 1'b0);
    checks++;
    if (mw_cycles !== 3 || rw_cycles !== 0) begin
      errors++;
      $display("FAIL sw_wait_counts: got MemWrite=%0d RegWrite=%0d expected 3 0", mw_cycles, rw_cycles);
    end
    run_instr(OP_I, 0, 0, 1'b0);  // confirms return to FETCH
  endtask

  task automatic test_alu_branch();
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_I, 0, 0, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_JAL, 0, 0, 1'b0);
  endtask

  task automatic test_illegal_lui();
    run_instr(OP_SYS, 0, 0, 1'b0);
    run_instr(OP_LUI, 0, 0, 1'b0);
  endtask

  task automatic test_fetch_wait();
    run_instr(OP_R, 4, 0, 1'b0);
  endtask

  task automatic test_back_to_back(input bit sel, input int n);
    for (int i = 0; i < n; i++) run_instr(rand_op(), -1, -1, sel);
  endtask

  task automatic test_no_utype_no_handshake();
    do_reset();
    run_instr(OP_LUI, 0, 0, 1'b1);
    run_instr(OP_SYS, 0, 0, 1'b1);
    run_instr(OP_LW, 4, 3, 1'b1);
    run_instr(OP_SW, 2, 2, 1'b1);
    test_back_to_back(1'b1, 30);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    reset_n = 1'b0;
    op = 7'd0;
    mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu_branch();
    test_illegal_lui();
    test_fetch_wait();
    test_back_to_back(1'b0, 60);
    test_no_utype_no_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
